// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_TIMEOUT_W     = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the RX FIFO: synchronous write port, asynchronous read port.
// Contents are not reset; the owner masks the read data while empty.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [UART_DATA_W-1:0] o_rd_data
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with sticky overflow, level-threshold interrupt and idle-timeout interrupt.
// Pointers wrap modulo DEPTH; occupancy is tracked by a separate up/down counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [UART_DATA_W-1:0]    rx_data,
  input  logic                      flush,
  input  logic                      rd_pop,
  input  logic                      ovf_clr,
  input  logic [LVLW-1:0]           cfg_thresh,
  input  logic [UART_TIMEOUT_W-1:0] cfg_timeout,
  output logic [UART_DATA_W-1:0]    rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [LVLW-1:0]           level,
  output logic                      ovf,
  output logic                      thresh_irq,
  output logic                      timeout_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [LVLW-1:0]           r_level;
  logic [UART_TIMEOUT_W-1:0] r_tcnt;
  logic                      r_ovf;
  logic                      r_tirq;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_idle_hit;
  logic [UART_DATA_W-1:0]    w_mem_rd;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVLW'(DEPTH));

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = rx_valid && (!w_full || rd_pop) && !flush;
  assign w_pop  = rd_pop && !w_empty && !flush;
  assign w_drop = rx_valid && w_full && !rd_pop;

  assign w_idle_hit = !w_empty && (cfg_timeout != '0) && !w_push && !w_pop &&
                      (r_tcnt == cfg_timeout - UART_TIMEOUT_W'(1));

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (rx_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVLW'(1);
        2'b01:   r_level <= r_level - LVLW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Idle counter only runs while data sits untouched; it saturates rather than wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (flush || w_push || w_pop || w_empty) begin
      r_tcnt <= '0;
    end else if (r_tcnt != '1) begin
      r_tcnt <= r_tcnt + UART_TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tirq <= 1'b0;
    end else if (flush || w_pop) begin
      r_tirq <= 1'b0;
    end else if (w_idle_hit) begin
      r_tirq <= 1'b1;
    end
  end

  // A new drop outranks a simultaneous clear so no overflow event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign rd_data     = w_empty ? '0 : w_mem_rd;
  assign empty       = w_empty;
  assign full        = w_full;
  assign level       = r_level;
  assign ovf         = r_ovf;
  assign thresh_irq  = (cfg_thresh != '0) && (r_level >= cfg_thresh);
  assign timeout_irq = r_tirq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        flush;
  logic        rd_pop;
  logic        ovf_clr;
  logic [4:0]  cfg_thresh;
  logic [15:0] cfg_timeout;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic        ovf;
  logic        thresh_irq;
  logic        timeout_irq;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .flush       (flush),
    .rd_pop      (rd_pop),
    .ovf_clr     (ovf_clr),
    .cfg_thresh  (cfg_thresh),
    .cfg_timeout (cfg_timeout),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .ovf         (ovf),
    .thresh_irq  (thresh_irq),
    .timeout_irq (timeout_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of pulse inputs, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p,
                               input logic f, input logic c);
    rx_valid = v;
    rx_data  = d;
    rd_pop   = p;
    flush    = f;
    ovf_clr  = c;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rd_pop   = 1'b0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst         = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    flush       = 1'b0;
    rd_pop      = 1'b0;
    ovf_clr     = 1'b0;
    cfg_thresh  = 5'd0;
    cfg_timeout = 16'd0;
    #1;
    checkOutput("rst_empty", 16'(empty), 16'd1);
    checkOutput("rst_full", 16'(full), 16'd0);
    checkOutput("rst_level", 16'(level), 16'd0);
    checkOutput("rst_rd_data", 16'(rd_data), 16'd0);
    checkOutput("rst_ovf", 16'(ovf), 16'd0);
    checkOutput("rst_tirq", 16'(timeout_irq), 16'd0);
    checkOutput("rst_thirq", 16'(thresh_irq), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic ordering
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    checkOutput("first_push_data", 16'(rd_data), 16'h11);
    checkOutput("first_push_level", 16'(level), 16'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checkOutput("three_head", 16'(rd_data), 16'h11);
    checkOutput("three_level", 16'(level), 16'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pop1_data", 16'(rd_data), 16'h22);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pop2_data", 16'(rd_data), 16'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pop3_empty", 16'(empty), 16'd1);
    checkOutput("pop3_rd_data", 16'(rd_data), 16'd0);

    // Pop on empty is ignored; push+pop on empty only pushes
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_pop_level", 16'(level), 16'd0);
    checkOutput("empty_pop_ovf", 16'(ovf), 16'd0);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_pushpop_level", 16'(level), 16'd1);
    checkOutput("empty_pushpop_data", 16'(rd_data), 16'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_pushpop_drain", 16'(empty), 16'd1);

    // Fill, overflow, set-wins-over-clear, drain
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("fill_full", 16'(full), 16'd1);
    checkOutput("fill_ovf", 16'(ovf), 16'd0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_full", 16'(full), 16'd1);
    checkOutput("ovf_set", 16'(ovf), 16'd1);
    checkOutput("ovf_level", 16'(level), 16'd16);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", 16'(ovf), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_clr", 16'(ovf), 16'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain_%0d", i), 16'(rd_data), 16'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_empty", 16'(empty), 16'd1);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpp_level", 16'(level), 16'd16);
    checkOutput("fullpp_ovf", 16'(ovf), 16'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("fullpp_rd_%0d", i), 16'(rd_data),
                  (i < 15) ? 16'(8'h21 + i) : 16'h55);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("fullpp_empty", 16'(empty), 16'd1);

    // Idle timeout: fires exactly 10 cycles after the push
    cfg_timeout = 16'd10;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("tout_k%0d", k), 16'(timeout_irq), (k == 10) ? 16'd1 : 16'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("tout_pop_clr", 16'(timeout_irq), 16'd0);
    cfg_timeout = 16'd4;
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("tout4_set", 16'(timeout_irq), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("tout_flush_clr", 16'(timeout_irq), 16'd0);
    checkOutput("tout_flush_level", 16'(level), 16'd0);
    cfg_timeout = 16'd0;

    // Threshold interrupt
    cfg_thresh = 5'd4;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("thr_below", 16'(thresh_irq), 16'd0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_at", 16'(thresh_irq), 16'd1);
    checkOutput("thr_level", 16'(level), 16'd4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("thr_fall", 16'(thresh_irq), 16'd0);
    cfg_thresh = 5'd3;
    #1;
    checkOutput("thr_cfg_live", 16'(thresh_irq), 16'd1);
    cfg_thresh = 5'd0;
    #1;
    checkOutput("thr_disabled", 16'(thresh_irq), 16'd0);
    checkOutput("thr_data_kept", 16'(rd_data), 16'h41);

    // Flush beats a simultaneous push; ovf survives flush
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_level", 16'(level), 16'd5);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_level", 16'(level), 16'd0);
    checkOutput("flush_empty", 16'(empty), 16'd1);
    checkOutput("flush_ovf0", 16'(ovf), 16'd0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("flush_pre_ovf", 16'(ovf), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_ovf_kept", 16'(ovf), 16'd1);
    checkOutput("flush2_level", 16'(level), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-fill
    cfg_thresh  = 5'd1;
    cfg_timeout = 16'd2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("midfill_tirq", 16'(timeout_irq), 16'd1);
    checkOutput("midfill_thirq", 16'(thresh_irq), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_empty", 16'(empty), 16'd1);
    checkOutput("arst_level", 16'(level), 16'd0);
    checkOutput("arst_rd_data", 16'(rd_data), 16'd0);
    checkOutput("arst_tirq", 16'(timeout_irq), 16'd0);
    checkOutput("arst_thirq", 16'(thresh_irq), 16'd0);
    checkOutput("arst_full", 16'(full), 16'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cfg_thresh  = 5'd0;
    cfg_timeout = 16'd0;
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_level", 16'(level), 16'd1);
    checkOutput("post_rst_data", 16'(rd_data), 16'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of byte entries (power of 2, 4..256).
REQ-002 Parameter: LVLW, default $clog2(DEPTH)+1, width of the level and threshold fields.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset: asynchronous, active-high.
REQ-005 rx_valid  in  1  one-cycle pulse from the receiver: a byte is complete.
REQ-006 rx_data  in  8  received byte; valid only when rx_valid=1.
REQ-007 flush  in  1  synchronous clear of the FIFO contents and the timeout state.
REQ-008 rd_pop  in  1  consumer removes the head entry.
REQ-009 ovf_clr  in  1  clears the sticky overflow flag.
REQ-010 cfg_thresh  in  LVLW  level threshold for the interrupt; 0 disables it.
REQ-011 cfg_timeout  in  16  idle-timeout length in clk cycles; 0 disables it.
REQ-012 rd_data  out  8  head entry, first-word-fall-through; 0 when empty.
REQ-013 empty  out  1  level==0.
REQ-014 full  out  1  level==DEPTH.
REQ-015 level  out  LVLW  current occupancy, 0..DEPTH.
REQ-016 ovf  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-017 thresh_irq  out  1  level>=cfg_thresh, and cfg_thresh!=0.
REQ-018 timeout_irq  out  1  sticky: the FIFO is non-empty and has had no push/pop for cfg_timeout cycles.

Function
REQ-019 Push: rx_valid=1 and (!full or rd_pop=1) writes rx_data at the tail; the entry is visible on rd_data and counted in level one cycle later.
REQ-020 Pop: rd_pop=1 and !empty advances the head; the next entry appears on rd_data the following cycle.
REQ-021 Empty FIFO: rd_pop=1 is ignored; no state change and no error flag.
REQ-022 Full FIFO with rx_valid=1 and rd_pop=0: the byte is dropped, contents are unchanged, ovf is set the next cycle.
REQ-023 Full FIFO with rx_valid=1 and rd_pop=1: both are accepted, level stays DEPTH, ovf is not set.
REQ-024 Empty FIFO with rx_valid=1 and rd_pop=1: only the push takes effect; level becomes 1.
REQ-025 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; level is maintained as a separate up/down counter and never exceeds DEPTH.
REQ-026 ovf stays set until ovf_clr=1; if ovf_clr and a new overflow occur in the same cycle, set wins.
REQ-027 flush has priority over push and pop in the same cycle: level=0, pointers=0, timeout counter=0, timeout_irq=0; ovf is unaffected.
REQ-028 Timeout counter: reloads to 0 on any accepted push, any accepted pop, flush, or while empty; otherwise increments and saturates at 0xFFFF.
REQ-029 timeout_irq sets the cycle after the counter equals cfg_timeout-1 while non-empty and cfg_timeout!=0; it clears on the next accepted pop or on flush.
REQ-030 thresh_irq is combinational from the level register and cfg_thresh; it has no sticky state.
REQ-031 cfg_* may change at any time; a change takes effect the cycle it is applied, with no side effects on stored data.

Reset
REQ-032 rst=1 asynchronously forces: pointers=0, level=0, timeout counter=0, ovf=0, timeout_irq=0; as a result, empty=1, full=0, rd_data=0, thresh_irq=0.
REQ-033 Reset asserted mid-transfer discards all stored bytes; storage array contents need no reset but are never visible while empty.
REQ-034 Deassertion of rst is synchronous to clk by the system; the first push is accepted on the first edge after release.

Structure
REQ-035 uart_pkg holds: UART_DATA_W=8, UART_RX_FIFO_DEPTH=16, UART_TIMEOUT_W=16.
REQ-036 One sub-module, uart_fifo_mem: a DEPTH x 8 dual-port array with synchronous write and asynchronous read. The pointer, level, flag and timeout logic stays in uart_rx_fifo.

Verification
REQ-037 Push 0x11, 0x22, 0x33 -> rd_data=0x11 and level=3; pop three times -> rd_data sequence 0x22, 0x33, then empty=1.
REQ-038 Fill 16 bytes (0x00..0x0F), push 0xAA -> full=1, ovf=1, level=16; popping all returns 0x00..0x0F and 0xAA never appears.
REQ-039 Full FIFO, rx_valid and rd_pop in the same cycle with 0x55 -> level=16, ovf=0, 0x55 is the last byte read out.
REQ-040 cfg_timeout=10, push one byte, stay idle -> timeout_irq=1 exactly 10 cycles after the push; one pop -> timeout_irq=0.
REQ-041 cfg_thresh=4, push 4 bytes -> thresh_irq rises with level=4; pop 1 -> thresh_irq falls.
REQ-042 Assert flush and rx_valid together with 5 entries stored -> level=0 and empty=1 next cycle; ovf retains its prior value. Also: rst pulsed mid-fill -> all outputs return to their REQ-032 values immediately.
